aes_cmd_loader: RTL and testbench
=================================

AES_CMD_LOADER -- requirements
Module: aes_cmd_loader

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 32, payload bytes per key-load command.
REQ-002 SHALL have parameter STATE_BYTES, default 16, payload bytes per block-load command.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream command/payload byte valid.
REQ-006 SHALL have port in_byte  input  8  upstream byte.
REQ-007 SHALL have port in_ready  output  1  upstream byte accepted when in_valid&&in_ready at posedge.
REQ-008 SHALL have ports ld_key_valid  output  1, ld_key_byte  output  8, ld_key_ready  input  1: key byte stream to the AES core.
REQ-009 SHALL have ports ld_state_valid  output  1, ld_state_byte  output  8, ld_state_ready  input  1: state byte stream to the AES core.
REQ-010 SHALL have port start  output  1  one-cycle encryption start pulse to the core.
REQ-011 SHALL have port core_done  input  1  one-cycle completion pulse from the core.
REQ-012 SHALL have ports busy  output  1  (encryption in flight) and err  output  1  (sticky protocol error).

Function
REQ-013 SHALL implement states CMD, KEY, BLK, START, WAIT; reset state CMD.
REQ-014 In CMD, in_ready SHALL be 1; each accepted byte is decoded as a command: 0x00 NOP, 0x01 LOAD_KEY, 0x02 LOAD_BLK, 0x03 GO, 0x04 CLR_ERR.
REQ-015 NOP SHALL stay in CMD with no effect; CLR_ERR SHALL clear err the next cycle and stay in CMD.
REQ-016 LOAD_KEY SHALL go to KEY with byte counter cleared if key_loaded==0; else set err and stay in CMD.
REQ-017 LOAD_BLK SHALL go to BLK with counter cleared if blk_loaded==0; else set err and stay in CMD.
REQ-018 GO SHALL go to START if key_loaded && blk_loaded; else set err and stay in CMD.
REQ-019 Any other command byte SHALL set err and stay in CMD; the byte is consumed.
REQ-020 In KEY: ld_key_valid=in_valid, ld_key_byte=in_byte, in_ready=ld_key_ready (combinational pass-through, zero added latency, no buffering).
REQ-021 In BLK: ld_state_valid=in_valid, ld_state_byte=in_byte, in_ready=ld_state_ready (same pass-through rule).
REQ-022 The counter (6 bits) SHALL increment only on a completed transfer (in_valid && in_ready); stalls of any length hold it.
REQ-023 On the KEY_BYTES-th transfer in KEY, key_loaded SHALL set and state return to CMD the next cycle; likewise STATE_BYTES / blk_loaded in BLK.
REQ-024 Outside KEY, ld_key_valid SHALL be 0; outside BLK, ld_state_valid SHALL be 0; byte outputs are don't-care while their valid is 0.
REQ-025 START SHALL last exactly one cycle with start=1 and in_ready=0, then go to WAIT.
REQ-026 In WAIT, in_ready SHALL be 0 and busy SHALL be 1; on core_done, blk_loaded SHALL clear and state return to CMD the next cycle; key_loaded SHALL remain set.
REQ-027 busy SHALL be 1 in START and WAIT, 0 otherwise.
REQ-028 core_done outside WAIT SHALL be ignored.
REQ-029 start SHALL never be 1 in the same cycle as ld_key_valid or ld_state_valid.
REQ-030 err SHALL be sticky until CLR_ERR or reset; a new error with err already set leaves it 1.

Reset
REQ-031 Asserting rst_n low at any time, including mid-payload or in WAIT, SHALL immediately force state CMD, counter 0, key_loaded=0, blk_loaded=0, err=0.
REQ-032 During reset: in_ready=0, ld_key_valid=0, ld_state_valid=0, start=0, busy=0, err=0; in_ready goes to 1 on the first cycle after release.

Verification
REQ-033 Bench SHALL send 0x01 + 32 bytes 0x00..0x1F with ld_key_ready=1 -> ld_key_byte sequence 0x00..0x1F, 32 ld_key_valid beats, key_loaded=1, state CMD.
REQ-034 Bench SHALL send 0x02 + 16 bytes with ld_state_ready toggling every other cycle -> exactly 16 transfers in order, in_ready mirrors ld_state_ready, no byte lost or duplicated.
REQ-035 Bench SHALL send 0x03 after a full key and block -> start high exactly 1 cycle, busy=1 until core_done pulse injected 20 cycles later, then 0x02 accepted and 0x01 raises err.
REQ-036 Bench SHALL send 0x03 with no block loaded, then 0x7F -> err=1 after the first and stays 1; 0x04 -> err=0.
REQ-037 Bench SHALL assert rst_n low after 10 of 32 key bytes -> all outputs 0; after release, a full 0x01 + 32-byte load completes normally.

Source files
------------

// File: rtl/aes_cmd_loader.sv
// Command decoder and byte loader sitting between a byte stream and an AES core.
// Key and block payloads pass through combinationally; GO launches the core and
// waits for its completion pulse.
module aes_cmd_loader #(
  parameter int unsigned KEY_BYTES   = 32,
  parameter int unsigned STATE_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       ld_key_valid,
  output logic [7:0] ld_key_byte,
  input  logic       ld_key_ready,
  output logic       ld_state_valid,
  output logic [7:0] ld_state_byte,
  input  logic       ld_state_ready,
  output logic       start,
  input  logic       core_done,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CNT_W = 6;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_LOAD_KEY = 8'h01;
  localparam logic [7:0] CMD_LOAD_BLK = 8'h02;
  localparam logic [7:0] CMD_GO       = 8'h03;
  localparam logic [7:0] CMD_CLR_ERR  = 8'h04;

  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(STATE_BYTES - 1);

  typedef enum logic [2:0] {
    S_CMD,
    S_KEY,
    S_BLK,
    S_START,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_loaded_q, key_loaded_d;
  logic             blk_loaded_q, blk_loaded_d;
  logic             err_q, err_d;
  logic             run_q;
  logic             start_q, busy_q;

  // State and bookkeeping registers; run_q holds in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CMD;
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
      blk_loaded_q <= 1'b0;
      err_q        <= 1'b0;
      run_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_loaded_q <= key_loaded_d;
      blk_loaded_q <= blk_loaded_d;
      err_q        <= err_d;
      run_q        <= 1'b1;
      start_q      <= (state_d == S_START);
      busy_q       <= (state_d == S_START) || (state_d == S_WAIT);
    end
  end

  // Next-state, command decode and stream pass-through
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    key_loaded_d   = key_loaded_q;
    blk_loaded_d   = blk_loaded_q;
    err_d          = err_q;
    in_ready       = 1'b0;
    ld_key_valid   = 1'b0;
    ld_key_byte    = in_byte;
    ld_state_valid = 1'b0;
    ld_state_byte  = in_byte;

    unique case (state_q)
      S_CMD: begin
        in_ready = run_q;
        if (in_valid && run_q) begin
          unique case (in_byte)
            CMD_NOP: ;
            CMD_CLR_ERR: err_d = 1'b0;
            CMD_LOAD_KEY: begin
              if (!key_loaded_q) begin
                state_d = S_KEY;
                cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_LOAD_BLK: begin
              if (!blk_loaded_q) begin
                state_d = S_BLK;
                cnt_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_GO: begin
              if (key_loaded_q && blk_loaded_q) state_d = S_START;
              else err_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_KEY: begin
        ld_key_valid = in_valid;
        in_ready     = ld_key_ready;
        if (in_valid && ld_key_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == KEY_LAST) begin
            key_loaded_d = 1'b1;
            state_d      = S_CMD;
          end
        end
      end
      S_BLK: begin
        ld_state_valid = in_valid;
        in_ready       = ld_state_ready;
        if (in_valid && ld_state_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLK_LAST) begin
            blk_loaded_d = 1'b1;
            state_d      = S_CMD;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          blk_loaded_d = 1'b0;
          state_d      = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  assign start = start_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_aes_cmd_loader.sv
// Scoreboard bench for aes_cmd_loader: expected stream bytes queued as driven,
// compared against bytes captured on the load-port handshakes.
module tb_aes_cmd_loader;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       ld_key_valid;
  logic [7:0] ld_key_byte;
  logic       ld_key_ready;
  logic       ld_state_valid;
  logic [7:0] ld_state_byte;
  logic       ld_state_ready;
  logic       start;
  logic       core_done;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] key_exp[$];
  logic [7:0] blk_exp[$];
  logic [7:0] key_obs[$];
  logic [7:0] blk_obs[$];
  int key_rd = 0;
  int blk_rd = 0;
  int start_cnt = 0;
  int overlap_cnt = 0;

  bit toggle_rdy = 0;
  bit mirror_chk = 0;

  aes_cmd_loader #(.KEY_BYTES(32), .STATE_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .ld_key_valid(ld_key_valid), .ld_key_byte(ld_key_byte), .ld_key_ready(ld_key_ready),
    .ld_state_valid(ld_state_valid), .ld_state_byte(ld_state_byte), .ld_state_ready(ld_state_ready),
    .start(start), .core_done(core_done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture handshakes and start pulses as seen just before each edge
  always @(posedge clk) begin
    if (ld_key_valid && ld_key_ready) key_obs.push_back(ld_key_byte);
    if (ld_state_valid && ld_state_ready) blk_obs.push_back(ld_state_byte);
    if (start) start_cnt++;
    if (start && (ld_key_valid || ld_state_valid)) overlap_cnt++;
  end

  // Offer one byte starting at a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!done && n < 64) begin
      if (toggle_rdy) ld_state_ready = ~ld_state_ready;
      #1;
      if (mirror_chk) begin
        checks++;
        if (in_ready !== ld_state_ready) begin
          errors++;
          $display("FAIL blk_ready_mirror: in_ready=%b ld_state_ready=%b", in_ready, ld_state_ready);
        end
      end
      done = (in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted, required acceptance within 64 cycles", b);
    end
  endtask

  task automatic send_key_payload(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      key_exp.push_back(8'(i));
      send_byte(8'(i));
    end
  endtask

  task automatic send_blk_payload();
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      blk_exp.push_back(b);
      send_byte(b);
    end
  endtask

  task automatic check_key_stream(input string name);
    logic [7:0] e;
    checks++;
    if (key_obs.size() - key_rd !== key_exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, key_obs.size() - key_rd, key_exp.size());
    end
    while (key_exp.size() > 0 && key_rd < key_obs.size()) begin
      e = key_exp.pop_front();
      checks++;
      if (key_obs[key_rd] !== e) begin
        errors++;
        $display("FAIL %s_byte: got %02h, required %02h", name, key_obs[key_rd], e);
      end
      key_rd++;
    end
    key_exp.delete();
    key_rd = key_obs.size();
  endtask

  task automatic check_blk_stream(input string name);
    logic [7:0] e;
    checks++;
    if (blk_obs.size() - blk_rd !== blk_exp.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, blk_obs.size() - blk_rd, blk_exp.size());
    end
    while (blk_exp.size() > 0 && blk_rd < blk_obs.size()) begin
      e = blk_exp.pop_front();
      checks++;
      if (blk_obs[blk_rd] !== e) begin
        errors++;
        $display("FAIL %s_byte: got %02h, required %02h", name, blk_obs[blk_rd], e);
      end
      blk_rd++;
    end
    blk_exp.delete();
    blk_rd = blk_obs.size();
  endtask

  task automatic check_err(input string name, input logic exp);
    checks++;
    if (err !== exp) begin
      errors++;
      $display("FAIL %s: err=%b required %b", name, err, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({in_ready, ld_key_valid, ld_state_valid, start, busy, err} !== 6'b0) begin
      errors++;
      $display("FAIL %s: in_ready=%b key_v=%b state_v=%b start=%b busy=%b err=%b required all 0",
               name, in_ready, ld_key_valid, ld_state_valid, start, busy, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_cmd_errors();
    send_byte(8'h03);
    check_err("go_without_block", 1'b1);
    send_byte(8'h7F);
    check_err("bad_cmd_sticky", 1'b1);
    send_byte(8'h00);
    check_err("nop_keeps_err", 1'b1);
    send_byte(8'h04);
    check_err("clr_err", 1'b0);
  endtask

  task automatic test_key_load();
    send_byte(8'h01);
    send_key_payload(32);
    check_key_stream("key_load");
    in_valid = 1'b1;
    in_byte  = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b1 || ld_key_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_back_to_cmd: in_ready=%b ld_key_valid=%b required 1/0", in_ready, ld_key_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    send_byte(8'h01);
    check_err("key_loaded_reload", 1'b1);
    send_byte(8'h04);
    check_err("key_clr", 1'b0);
  endtask

  task automatic test_blk_toggle();
    send_byte(8'h02);
    toggle_rdy = 1;
    mirror_chk = 1;
    send_blk_payload();
    toggle_rdy = 0;
    mirror_chk = 0;
    ld_state_ready = 1'b1;
    check_blk_stream("blk_toggle");
    check_err("blk_no_err", 1'b0);
  endtask

  task automatic test_go();
    int s0 = start_cnt;
    send_byte(8'h03);
    #1;
    checks++;
    if (start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL go_start: start=%b busy=%b in_ready=%b required 1/1/0", start, busy, in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      #1;
      checks++;
      if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL go_wait_%0d: start=%b busy=%b in_ready=%b required 0/1/0", i, start, busy, in_ready);
      end
      @(negedge clk);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL go_done: busy=%b in_ready=%b required 0/1", busy, in_ready);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL go_start_cycles: got %0d start cycles, required 1", start_cnt - s0);
    end
    @(negedge clk);
    send_byte(8'h02);
    check_err("blk_after_done", 1'b0);
    send_blk_payload();
    check_blk_stream("blk_after_done");
    send_byte(8'h01);
    check_err("key_still_loaded", 1'b1);
    send_byte(8'h04);
    check_err("go_clr", 1'b0);
  endtask

  task automatic test_reset_mid_key();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h01);
    send_key_payload(10);
    check_key_stream("partial_key");
    in_valid = 1'b1;
    in_byte  = 8'h55;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("mid_key_reset");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h01);
    send_key_payload(32);
    check_key_stream("reload_key");
    send_byte(8'h01);
    check_err("reload_key_loaded", 1'b1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_byte        = 8'h00;
    ld_key_ready   = 1'b1;
    ld_state_ready = 1'b1;
    core_done      = 1'b0;
    @(negedge clk);
    test_reset();
    test_cmd_errors();
    test_key_load();
    test_blk_toggle();
    test_go();
    test_reset_mid_key();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL start_overlap: got %0d overlapping cycles, required 0", overlap_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
